// File: rtl/ow_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO, returning 1-wire master results to the host.
// Frames are sent LSB first and back-to-back while the FIFO holds data.
module ow_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_tx_dv,
  input  logic [7:0]                      i_tx_byte,
  output logic                            o_tx_ready,
  output logic                            o_tx_serial,
  output logic                            o_tx_active,
  output logic                            o_tx_done,
  output logic                            o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers; the extra pointer MSB separates full from empty
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          ready_q;
  logic          overflow_q;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  // shifter state
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] baud_q;
  logic [CW-1:0] baud_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          serial_q;
  logic          serial_d;
  logic          done_q;
  logic          done_d;
  logic          active_q;
  logic          baud_last;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = i_tx_dv && !fifo_full;
  assign baud_last  = (baud_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_tx_dv && !fifo_full) begin
      mem[wr_ptr_q[AW-1:0]] <= i_tx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      level_q    <= level_d;
      ready_q    <= (level_d != LW'(FIFO_DEPTH));
      overflow_q <= i_tx_dv && fifo_full;
    end
  end

  // Frame sequencer; outputs below are registered, so the line trails the state by one clk
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    serial_d = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q[AW-1:0]];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = CW'(baud_q + CW'(1));
        end
      end
      DATA: begin
        serial_d = shift_q[bit_q];
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = CW'(baud_q + CW'(1));
        end
      end
      STOP: begin
        serial_d = 1'b1;
        if (baud_last) begin
          done_d = 1'b1;
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q[AW-1:0]];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = CW'(baud_q + CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      active_q <= (state_q != IDLE);
    end
  end

  assign o_tx_ready   = ready_q;
  assign o_tx_serial  = serial_q;
  assign o_tx_active  = active_q;
  assign o_tx_done    = done_q;
  assign o_overflow   = overflow_q;
  assign o_fifo_level = level_q;

endmodule

// File: tb/tb_ow_uart_tx.sv
// Directed bench for ow_uart_tx with a line-level UART monitor collecting received bytes.
module tb_ow_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       i_tx_dv;
  logic [7:0] i_tx_byte;
  logic       o_tx_ready;
  logic       o_tx_serial;
  logic       o_tx_active;
  logic       o_tx_done;
  logic       o_overflow;
  logic [2:0] o_fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] rx_q [$];

  ow_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_tx_dv      (i_tx_dv),
    .i_tx_byte    (i_tx_byte),
    .o_tx_ready   (o_tx_ready),
    .o_tx_serial  (o_tx_serial),
    .o_tx_active  (o_tx_active),
    .o_tx_done    (o_tx_done),
    .o_overflow   (o_overflow),
    .o_fifo_level (o_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Single write; returns the cycle number of the write edge
  task automatic write1(input logic [7:0] b, output int n);
    i_tx_dv   = 1'b1;
    i_tx_byte = b;
    @(posedge clk); #1;
    n = cyc;
    i_tx_dv = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((o_tx_active || o_fifo_level != 3'd0) && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    step(3);
  endtask

  // UART monitor: samples each bit in its second clk
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (o_tx_serial === 1'b0) begin
        repeat (CPB + 1) @(posedge clk);
        #1 b[0] = o_tx_serial;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1 b[i] = o_tx_serial;
        end
        repeat (CPB) @(posedge clk);
        #1 chk("stop_bit", 32'(o_tx_serial), 32'd1);
        rx_q.push_back(b);
        repeat (2) @(posedge clk);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sent;
    int k;
    logic flag;
    logic low_seen;
    logic [7:0] a5;
    logic [7:0] exp_b;

    rst       = 1'b1;
    i_tx_dv   = 1'b0;
    i_tx_byte = 8'h00;
    step(3);
    rst = 1'b0;
    chk("rst_serial", 32'(o_tx_serial), 32'd1);
    chk("rst_active", 32'(o_tx_active), 32'd0);
    chk("rst_done",   32'(o_tx_done),   32'd0);
    chk("rst_ovf",    32'(o_overflow),  32'd0);
    chk("rst_level",  32'(o_fifo_level), 32'd0);
    chk("rst_ready",  32'(o_tx_ready),  32'd1);
    step(3);

    // 1: single frame 0xA5 with exact timing
    a5 = 8'hA5;
    write1(a5, n);
    chk("t1_level_n", 32'(o_fifo_level), 32'd1);
    wait_until(n + 1);
    chk("t1_line_n1", 32'(o_tx_serial), 32'd1);
    wait_until(n + 2);
    chk("t1_start_n2", 32'(o_tx_serial), 32'd0);
    chk("t1_active_n2", 32'(o_tx_active), 32'd1);
    wait_until(n + 5);
    chk("t1_start_n5", 32'(o_tx_serial), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wait_until(n + 7 + 4 * i);
      chk("t1_data_bit", 32'(o_tx_serial), 32'(a5[i]));
    end
    wait_until(n + 38);
    chk("t1_stop", 32'(o_tx_serial), 32'd1);
    wait_until(n + 40);
    chk("t1_done_n40", 32'(o_tx_done), 32'd0);
    wait_until(n + 41);
    chk("t1_done_n41", 32'(o_tx_done), 32'd1);
    chk("t1_active_n41", 32'(o_tx_active), 32'd1);
    wait_until(n + 42);
    chk("t1_done_n42", 32'(o_tx_done), 32'd0);
    chk("t1_active_n42", 32'(o_tx_active), 32'd0);
    wait_rx(1, 100);
    if (rx_q.size() >= 1) chk("t1_rx", 32'(rx_q[0]), 32'hA5);
    rx_q.delete();
    wait_idle();

    // 2: two consecutive writes, zero-gap frames
    i_tx_dv = 1'b1; i_tx_byte = 8'h00;
    @(posedge clk); #1;
    n = cyc;
    chk("t2_level_n", 32'(o_fifo_level), 32'd1);
    i_tx_byte = 8'hFF;
    @(posedge clk); #1;
    i_tx_dv = 1'b0;
    chk("t2_level_n1", 32'(o_fifo_level), 32'd1);
    wait_until(n + 40);
    chk("t2_level_n40", 32'(o_fifo_level), 32'd1);
    wait_until(n + 41);
    chk("t2_stop_last", 32'(o_tx_serial), 32'd1);
    chk("t2_done", 32'(o_tx_done), 32'd1);
    chk("t2_level_n41", 32'(o_fifo_level), 32'd0);
    wait_until(n + 42);
    chk("t2_start2", 32'(o_tx_serial), 32'd0);
    chk("t2_active_gap", 32'(o_tx_active), 32'd1);
    wait_rx(2, 200);
    if (rx_q.size() >= 2) begin
      chk("t2_rx0", 32'(rx_q[0]), 32'h00);
      chk("t2_rx1", 32'(rx_q[1]), 32'hFF);
    end
    rx_q.delete();
    wait_idle();

    // 3: overflow on the sixth consecutive write
    i_tx_dv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_tx_byte = 8'(i + 1);
      @(posedge clk); #1;
      if (i == 4) begin
        chk("t3_level_full", 32'(o_fifo_level), 32'd4);
        chk("t3_ready_full", 32'(o_tx_ready), 32'd0);
        chk("t3_ovf_before", 32'(o_overflow), 32'd0);
      end
    end
    i_tx_dv = 1'b0;
    chk("t3_ovf_pulse", 32'(o_overflow), 32'd1);
    chk("t3_level_kept", 32'(o_fifo_level), 32'd4);
    step(1);
    chk("t3_ovf_single", 32'(o_overflow), 32'd0);
    wait_rx(5, 400);
    step(60);
    chk("t3_rx_total", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (rx_q.size() > i) chk("t3_rx_order", 32'(rx_q[i]), 32'(i + 1));
    end
    rx_q.delete();
    wait_idle();

    // 4: reset during data bit 3 of 0x3C, then recover
    write1(8'h3C, n);
    wait_until(n + 18);
    rst = 1'b1;
    wait_until(n + 19);
    rst = 1'b0;
    chk("t4_line_high", 32'(o_tx_serial), 32'd1);
    chk("t4_level", 32'(o_fifo_level), 32'd0);
    chk("t4_active", 32'(o_tx_active), 32'd0);
    chk("t4_done", 32'(o_tx_done), 32'd0);
    flag = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (o_tx_done) flag = 1'b1;
      if (!o_tx_serial) low_seen = 1'b1;
    end
    chk("t4_no_done", 32'(flag), 32'd0);
    chk("t4_no_bits", 32'(low_seen), 32'd0);
    rx_q.delete();
    write1(8'h55, n);
    wait_rx(1, 100);
    if (rx_q.size() >= 1) chk("t4_rx55", 32'(rx_q[0]), 32'h55);
    rx_q.delete();
    wait_idle();

    // 5: stream ten bytes through the wrapping FIFO
    sent = 0;
    k = 0;
    flag = 1'b0;
    while (sent < 10 && k < 2000) begin
      if (o_tx_ready) begin
        i_tx_dv = 1'b1;
        i_tx_byte = 8'(8'h10 + sent);
      end else begin
        i_tx_dv = 1'b0;
      end
      @(posedge clk); #1;
      if (i_tx_dv) sent++;
      if (o_overflow) flag = 1'b1;
      k++;
    end
    i_tx_dv = 1'b0;
    step(1);
    if (o_overflow) flag = 1'b1;
    chk("t5_sent", 32'(sent), 32'd10);
    chk("t5_no_ovf", 32'(flag), 32'd0);
    wait_rx(10, 800);
    for (int i = 0; i < 10; i++) begin
      exp_b = 8'(8'h10 + i);
      if (rx_q.size() > i) chk("t5_rx_order", 32'(rx_q[i]), 32'(exp_b));
    end
    rx_q.delete();
    wait_idle();

    // 6: byte input changes right after the write edge
    write1(8'h81, n);
    i_tx_byte = 8'h7E;
    wait_rx(1, 100);
    if (rx_q.size() >= 1) chk("t6_rx81", 32'(rx_q[0]), 32'h81);
    rx_q.delete();
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
